// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module   : hazard_ctrl_pkg
// Brief    : Shared stall-bus layout and multiply/divide sequencer encodings.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam int STALL_W   = 4;
    localparam int STALL_PC  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;

    // Wide enough to preload MDU_LATENCY-2 for the largest legal latency (255).
    localparam int MDU_CNT_W = 8;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_BUSY = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_t;

    function automatic logic [STALL_W-1:0] stall_upto(input int top_bit);
        logic [STALL_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < STALL_W; i++) begin
            if (i <= top_bit) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_mdu_seq.sv
// ============================================================================
// Module   : hazard_mdu_seq
// Brief    : Multiply/divide sequencer: holds the front end for MDU_LATENCY
//            cycles per op and pulses seq_done when the result is valid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_mdu_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic abort,
    output logic seq_stall,
    output logic seq_busy,
    output logic seq_done
);

    // The start cycle itself is a stall cycle, so BUSY lasts MDU_LATENCY-1.
    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);

    seq_state_t             state;
    seq_state_t             state_nxt;
    logic [MDU_CNT_W-1:0]   cnt;
    logic [MDU_CNT_W-1:0]   cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seq_stall = 1'b0;
        seq_busy  = 1'b0;
        seq_done  = 1'b0;

        case (state)
            SEQ_IDLE: begin
                if (md_start) begin
                    state_nxt = SEQ_BUSY;
                    cnt_nxt   = CNT_LOAD;
                    seq_stall = 1'b1;
                end
            end
            SEQ_BUSY: begin
                seq_busy  = 1'b1;
                seq_stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = SEQ_DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            SEQ_DONE: begin
                seq_busy = 1'b1;
                seq_done = 1'b1;
                if (md_start) begin
                    state_nxt = SEQ_BUSY;
                    cnt_nxt   = CNT_LOAD;
                    seq_stall = 1'b1;
                end else begin
                    state_nxt = SEQ_IDLE;
                end
            end
            default: begin
                state_nxt = SEQ_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (abort) begin
            state_nxt = SEQ_IDLE;
            cnt_nxt   = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard controller: load-use detection, multiply/divide
//            stall sequencing, exception flush priority and stall statistics.
//            Define HAZARD_MDU_EN to build the multiply/divide sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_rs_read,
    input  logic                   id_rt_read,
    input  logic                   ex_load,
    input  logic                   ex_wreg_en,
    input  logic [4:0]             ex_wreg_addr,
    input  logic                   md_start,
    input  logic                   exc_req,
    output logic [STALL_W-1:0]     stall,
    output logic                   flush,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic               load_use;
    logic               rs_hit;
    logic               rt_hit;
    logic               seq_stall;
    logic               seq_busy;
    logic               seq_done;
    logic [STALL_W-1:0] stall_merged;

    assign rs_hit   = id_rs_read && (id_rs == ex_wreg_addr);
    assign rt_hit   = id_rt_read && (id_rt == ex_wreg_addr);
    assign load_use = ex_load && ex_wreg_en && (ex_wreg_addr != 5'd0) && (rs_hit || rt_hit);

`ifdef HAZARD_MDU_EN
    hazard_mdu_seq #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_start  (md_start),
        .abort     (exc_req),
        .seq_stall (seq_stall),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done)
    );
`else
    logic unused_mdu;
    assign unused_mdu = &{1'b0, md_start, 8'(MDU_LATENCY)};
    assign seq_stall  = 1'b0;
    assign seq_busy   = 1'b0;
    assign seq_done   = 1'b0;
`endif

    // Load-use bubbles EX; an MDU op also holds EX. An exception overrides both.
    always_comb begin
        stall_merged = '0;
        if (load_use) begin
            stall_merged = stall_merged | stall_upto(STALL_ID);
        end
        if (seq_stall) begin
            stall_merged = stall_merged | stall_upto(STALL_EX);
        end
        stall_merged[STALL_MEM] = 1'b0;
        if (exc_req) begin
            stall_merged = '0;
        end
    end

    assign stall   = rst_n ? stall_merged : '0;
    assign flush   = rst_n && exc_req;
    assign md_busy = rst_n && seq_busy;
    assign md_done = rst_n && seq_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall[STALL_ID] && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl (directed + random stimulus).
//            Honours HAZARD_MDU_EN in the same way as the design.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int LAT    = 32;
    localparam int CNT_W  = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_wreg_addr;
    logic             id_rs_read, id_rt_read, ex_load, ex_wreg_en, md_start, exc_req;
    logic [3:0]       stall;
    logic             flush, md_busy, md_done;
    logic [CNT_W-1:0] stall_cycles;

    int passed = 0;
    int total  = 0;

    // Reference model: k = cycles since the accepted start of the current op
    // (-1 when no op). Stall while k in 0..LAT-1, result valid at k==LAT.
    int k          = -1;
    int sc         = 0;
    int cyc        = 0;
    int done_count = 0;
    int last_done  = -1;

    hazard_ctrl #(
        .MDU_LATENCY (LAT),
        .STALL_CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_read   (id_rs_read),
        .id_rt_read   (id_rt_read),
        .ex_load      (ex_load),
        .ex_wreg_en   (ex_wreg_en),
        .ex_wreg_addr (ex_wreg_addr),
        .md_start     (md_start),
        .exc_req      (exc_req),
        .stall        (stall),
        .flush        (flush),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_rs_read = 1'b0; id_rt_read = 1'b0;
        ex_load = 1'b0; ex_wreg_en = 1'b0; ex_wreg_addr = 5'd0;
        md_start = 1'b0; exc_req = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] addr, input logic [4:0] rs, input logic rs_rd,
                            input logic [4:0] rt, input logic rt_rd);
        ex_load = 1'b1; ex_wreg_en = 1'b1; ex_wreg_addr = addr;
        id_rs = rs; id_rs_read = rs_rd; id_rt = rt; id_rt_read = rt_rd;
    endtask

    // One clock: outputs checked at the falling edge, model advanced at the rising edge.
    task automatic cycle();
        logic lu, start_ok, sst, bsy, dn;
        logic [3:0] es;
        lu = ex_load && ex_wreg_en && (ex_wreg_addr != 0) &&
             ((id_rs_read && id_rs == ex_wreg_addr) || (id_rt_read && id_rt == ex_wreg_addr));
`ifdef HAZARD_MDU_EN
        start_ok = md_start && (k < 0 || k == LAT);
        sst      = start_ok || (k >= 1 && k < LAT);
        bsy      = (k >= 1 && k <= LAT);
        dn       = (k == LAT);
`else
        start_ok = 1'b0; sst = 1'b0; bsy = 1'b0; dn = 1'b0;
`endif
        es = exc_req ? 4'b0000 : sst ? 4'b0111 : lu ? 4'b0011 : 4'b0000;
        @(negedge clk);
        check("stall", 32'(stall), 32'(es));
        check("flush", 32'(flush), 32'(exc_req));
        check("md_busy", 32'(md_busy), 32'(bsy));
        check("md_done", 32'(md_done), 32'(dn));
        check("stall_cycles", 32'(stall_cycles), 32'(sc));
        if (md_done) begin
            done_count++;
            last_done = cyc;
        end
        @(posedge clk);
        if (es[1] && sc < CNT_MAX) sc++;
        if (exc_req)                  k = -1;
        else if (start_ok)            k = 1;
        else if (k >= 1 && k < LAT)   k = k + 1;
        else if (k == LAT)            k = -1;
        cyc++;
        #1;
    endtask

    // Reset asserted between edges with whatever inputs are currently driven.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_done", 32'(md_done), 32'd0);
        check("rst_cnt", 32'(stall_cycles), 32'd0);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        k = -1; sc = 0; done_count = 0; last_done = -1;
    endtask

    initial begin
        int start_cyc;
        rst_n = 1'b1;
        idle_inputs();
        // Active hazard inputs during reset must not leak to the outputs.
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        md_start = 1'b1;
        exc_req  = 1'b1;
        #1;
        do_reset();

        // Load-use detection corners.
        set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);  cycle();
        check("lu_rs_hit", 32'(stall), 32'b0011);
        set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);  cycle();
        check("lu_r0", 32'(stall), 32'b0000);
        set_load(5'd9, 5'd1, 1'b1, 5'd9, 1'b1);  cycle();
        set_load(5'd9, 5'd9, 1'b0, 5'd2, 1'b1);  cycle();
        set_load(5'd7, 5'd7, 1'b1, 5'd7, 1'b1);  ex_wreg_en = 1'b0; cycle();
        set_load(5'd7, 5'd7, 1'b1, 5'd7, 1'b1);  ex_load = 1'b0;    cycle();
        set_load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);  exc_req = 1'b1;    cycle();
        idle_inputs(); cycle();

        // Single op from a clean counter.
        do_reset();
        repeat (10) cycle();
        start_cyc = cyc;
        md_start = 1'b1; cycle();
        md_start = 1'b0; repeat (40) cycle();
`ifdef HAZARD_MDU_EN
        check("op_done_count", 32'(done_count), 32'd1);
        check("op_done_cycle", 32'(last_done), 32'(start_cyc + LAT));
        check("op_stall_cycles", 32'(stall_cycles), 32'd32);
`else
        check("op_done_count", 32'(done_count), 32'd0);
        check("op_stall_cycles", 32'(stall_cycles), 32'd0);
`endif

        // Exception mid-op aborts without a result pulse.
        do_reset();
        md_start = 1'b1; cycle();
        md_start = 1'b0; repeat (9) cycle();
        exc_req = 1'b1; cycle();
        exc_req = 1'b0; repeat (40) cycle();
        check("abort_done_count", 32'(done_count), 32'd0);

        // Restart in the result cycle, then md_start held through BUSY.
        do_reset();
        md_start = 1'b1; cycle();
        md_start = 1'b0; repeat (LAT - 1) cycle();
        start_cyc = cyc;
        md_start = 1'b1; repeat (12) cycle();
        md_start = 1'b0; repeat (40) cycle();
`ifdef HAZARD_MDU_EN
        check("restart_done_count", 32'(done_count), 32'd2);
        check("restart_done_cycle", 32'(last_done), 32'(start_cyc + LAT));
`else
        check("restart_done_count", 32'(done_count), 32'd0);
`endif

        // Reset in the middle of an op.
        md_start = 1'b1; cycle();
        md_start = 1'b0; repeat (12) cycle();
        set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        do_reset();
        repeat (40) cycle();
        check("postrst_done_count", 32'(done_count), 32'd0);

        // Randomised traffic, biased to small register indices to hit load-use.
        for (int i = 0; i < 600; i++) begin
            ex_load      = 1'($urandom_range(0, 1));
            ex_wreg_en   = ($urandom_range(0, 3) != 0);
            ex_wreg_addr = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_rs_read   = 1'($urandom_range(0, 1));
            id_rt_read   = 1'($urandom_range(0, 1));
            md_start     = ($urandom_range(0, 9) == 0);
            exc_req      = ($urandom_range(0, 39) == 0);
            cycle();
        end

        // Stall counter saturation.
        do_reset();
        set_load(5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
        repeat (CNT_MAX + 8) cycle();
        check("cnt_saturated", 32'(stall_cycles), 32'(CNT_MAX));
        idle_inputs(); cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LATENCY, default 32, total stall cycles per multiply/divide op (legal range 2..255).
REQ-002 SHALL have parameter STALL_CNT_W, default 32, stall-cycle counter width.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 id_rs  in  5  ID-stage source register 1 index.
REQ-006 id_rt  in  5  ID-stage source register 2 index.
REQ-007 id_rs_read  in  1  ID instruction reads id_rs.
REQ-008 id_rt_read  in  1  ID instruction reads id_rt.
REQ-009 ex_load  in  1  EX-stage instruction is a load.
REQ-010 ex_wreg_en  in  1  EX-stage instruction writes a register.
REQ-011 ex_wreg_addr  in  5  EX-stage destination register.
REQ-012 md_start  in  1  EX-stage instruction starts a multi-cycle multiply/divide.
REQ-013 exc_req  in  1  MEM-stage exception/flush request.
REQ-014 stall  out  4  per-stage hold: bit0 PC/IF, bit1 ID, bit2 EX, bit3 MEM.
REQ-015 flush  out  1  flush all stages.
REQ-016 md_busy  out  1  multiply/divide sequencer not idle.
REQ-017 md_done  out  1  one-cycle pulse when the multiply/divide result is valid.
REQ-018 stall_cycles  out  STALL_CNT_W  count of cycles with stall[1]=1.

Function
REQ-019 Load-use hazard SHALL be ex_load & ex_wreg_en & ex_wreg_addr!=0 & ((id_rs_read & id_rs==ex_wreg_addr) | (id_rt_read & id_rt==ex_wreg_addr)); when true, stall=4'b0011 combinationally in the same cycle (EX receives a bubble).
REQ-020 Sequencer states SHALL be IDLE, BUSY, DONE; md_busy=1 in BUSY and DONE.
REQ-021 IDLE or DONE with md_start=1 SHALL go to BUSY with cnt=MDU_LATENCY-2, asserting stall=4'b0111 combinationally in that start cycle.
REQ-022 BUSY SHALL assert stall=4'b0111 and decrement cnt each cycle; BUSY with cnt==0 goes to DONE.
REQ-023 md_start in BUSY SHALL be ignored.
REQ-024 DONE SHALL assert md_done=1 and stall=0 for exactly one cycle, then go to IDLE unless md_start=1 (REQ-021).
REQ-025 An op SHALL therefore stall ID exactly MDU_LATENCY cycles; md_done rises MDU_LATENCY cycles after the md_start cycle.
REQ-026 When load-use and sequencer stalls coincide, stall SHALL be their bitwise OR (0111).
REQ-027 exc_req SHALL have top priority: flush=1 and stall=0 in the same cycle; the sequencer goes to IDLE with cnt=0 next cycle and produces no md_done.
REQ-028 stall_cycles SHALL increment on every clock edge where stall[1]=1 and saturate at all-ones.
REQ-029 Reserved stall[3] SHALL be driven 0 (kept for future MEM-stage wait states).

Reset
REQ-030 While rst_n=0: state=IDLE, cnt=0, stall_cycles=0; stall, flush, md_busy and md_done are forced to 0 regardless of inputs.
REQ-031 Reset asserted mid-operation SHALL abort the sequencer with no md_done pulse after release.

Configuration
REQ-032 Macro HAZARD_MDU_EN: when defined, the sequencer (REQ-020..025, REQ-027 abort) is built; when undefined, md_start is ignored, md_busy=md_done=0, and stall derives only from load-use and exc_req.

Structure
REQ-033 The shared header SHALL hold the stall bus width, stall bit indices (STALL_PC, STALL_ID, STALL_EX, STALL_MEM) and sequencer state encodings.
REQ-034 The sequencer FSM and counter SHALL be the sub-module hazard_mdu_seq; hazard_ctrl holds load-use compare, priority merge and stall counter.

Verification
REQ-035 ex_load=1, ex_wreg_en=1, ex_wreg_addr=5, id_rs=5, id_rs_read=1 -> stall=0011 that cycle; with ex_wreg_addr=0 -> stall=0000.
REQ-036 MDU_LATENCY=32, md_start pulse at cycle 10 -> stall=0111 cycles 10..41, md_done=1 only at cycle 42, stall_cycles=32.
REQ-037 exc_req=1 at cycle 20 of the REQ-036 scenario -> flush=1, stall=0 at cycle 20, md_busy=0 from cycle 21, no md_done.
REQ-038 md_start during DONE -> BUSY next cycle, second md_done exactly MDU_LATENCY cycles later; md_start held high in BUSY -> no restart.
REQ-039 rst_n low at mid-BUSY -> all outputs 0 immediately (asynchronously); after release, state IDLE, stall_cycles=0.
REQ-040 Build without HAZARD_MDU_EN, md_start=1 -> stall=0000, md_busy=0, md_done=0.
